// File: rtl/opl3_pkg.sv
// Shared OPL3 types: the register-write bus seen by the register file and leds,
// plus the default host-port sizing constants.
package opl3_pkg;

    localparam int OPL3_FIFO_DEPTH = 16;
    localparam int OPL3_MIN_WR_GAP = 32;

    typedef struct packed {
        logic       valid;
        logic       bank_num;
        logic [7:0] address;
        logic [7:0] data;
    } opl3_reg_wr_t;

    typedef enum logic [1:0] {
        DRAIN_IDLE  = 2'd0,
        DRAIN_ISSUE = 2'd1,
        DRAIN_GAP   = 2'd2
    } drain_state_e;

endpackage

// File: rtl/opl3_host_fifo.sv
// Synchronous FIFO with push/pop and an occupancy count; full/empty derive from the count.
module opl3_host_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 17
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       head_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/opl3_host_port.sv
// OPL3 host write port: address latch, 17-bit write FIFO and drain FSM emitting reg-write pulses.
// Define OPL3_HOST_RATE_LIMIT_EN to space pulses at least MIN_WR_GAP+1 clocks apart.
module opl3_host_port
    import opl3_pkg::*;
#(
    parameter int FIFO_DEPTH = OPL3_FIFO_DEPTH,
    parameter int MIN_WR_GAP = OPL3_MIN_WR_GAP
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        host_valid,
    output logic                        host_ready,
    input  logic [1:0]                  host_a,
    input  logic [7:0]                  host_d,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output opl3_reg_wr_t                opl3_reg_wr,
    output drain_state_e                dbg_state
);

    // Handshake: a write transfers on a rising edge where host_valid && host_ready;
    // host_ready depends only on registered state, never on host_valid.

    logic         ready_en_q;
    logic [7:0]   addr_q;
    logic         bank_q;
    drain_state_e state_q, state_d;
    opl3_reg_wr_t out_q, out_d;
    logic         accept, push, pop, full, empty;
    logic [16:0]  head;

`ifdef OPL3_HOST_RATE_LIMIT_EN
    localparam int GW = $clog2(MIN_WR_GAP + 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(MIN_WR_GAP - 1);
    logic [GW-1:0] cnt_q, cnt_d;
`endif

    assign accept      = host_valid && host_ready;
    assign push        = accept && host_a[0];
    assign host_ready  = ready_en_q && !full;
    assign opl3_reg_wr = out_q;
    assign dbg_state   = state_q;

    opl3_host_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (17)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (push),
        .push_data_i ({bank_q, addr_q, host_d}),
        .pop_i       (pop),
        .head_o      (head),
        .level_o     (fifo_level),
        .full_o      (full),
        .empty_o     (empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_en_q <= 1'b0;
            addr_q     <= '0;
            bank_q     <= 1'b0;
            state_q    <= DRAIN_IDLE;
            out_q      <= '0;
`ifdef OPL3_HOST_RATE_LIMIT_EN
            cnt_q      <= '0;
`endif
        end else begin
            ready_en_q <= 1'b1;
            if (accept && !host_a[0]) begin
                addr_q <= host_d;
                bank_q <= host_a[1];
            end
            state_q <= state_d;
            out_q   <= out_d;
`ifdef OPL3_HOST_RATE_LIMIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
`ifdef OPL3_HOST_RATE_LIMIT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            DRAIN_IDLE: if (!empty) state_d = DRAIN_ISSUE;
            DRAIN_ISSUE: begin
`ifdef OPL3_HOST_RATE_LIMIT_EN
                // A gap of MIN_WR_GAP-1 cycles plus ISSUE and IDLE gives the full spacing.
                if (GAP_LOAD == '0) begin
                    state_d = DRAIN_IDLE;
                end else begin
                    state_d = DRAIN_GAP;
                    cnt_d   = GAP_LOAD;
                end
`else
                state_d = DRAIN_IDLE;
`endif
            end
            DRAIN_GAP: begin
`ifdef OPL3_HOST_RATE_LIMIT_EN
                if (cnt_q <= GW'(1)) begin
                    state_d = DRAIN_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - GW'(1);
                end
`else
                state_d = DRAIN_IDLE;
`endif
            end
            default: state_d = DRAIN_IDLE;
        endcase
    end

    always_comb begin
        pop         = 1'b0;
        out_d       = out_q;
        out_d.valid = 1'b0;
        if (state_q == DRAIN_IDLE && !empty) begin
            pop   = 1'b1;
            out_d = {1'b1, head};
        end
    end

endmodule

// File: tb/tb_opl3_host_port.sv
// Randomized bench for opl3_host_port: a write-level reference model feeds an expected-pulse queue.
module tb_opl3_host_port;
    import opl3_pkg::*;

    localparam int DEPTH = 16;
    localparam int GAP   = 32;
`ifdef OPL3_HOST_RATE_LIMIT_EN
    localparam int SP = GAP + 1;
`else
    localparam int SP = 2;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         host_valid = 1'b0;
    logic [1:0]   host_a = '0;
    logic [7:0]   host_d = '0;
    logic         host_ready;
    logic [4:0]   fifo_level;
    opl3_reg_wr_t opl3_reg_wr;
    drain_state_e dbg_state;

    opl3_host_port #(
        .FIFO_DEPTH (DEPTH),
        .MIN_WR_GAP (GAP)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .host_valid  (host_valid),
        .host_ready  (host_ready),
        .host_a      (host_a),
        .host_d      (host_d),
        .fifo_level  (fifo_level),
        .opl3_reg_wr (opl3_reg_wr),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    logic [16:0] exp_q[$];
    int          pulse_cyc[$];
    int          n_cmp = 0, n_err = 0;
    int          cyc = 0, pushes = 0, pulses = 0, acc_cyc = 0, stalls = 0;
    bit          mon_en = 1'b0, saw_full = 1'b0;
    logic [7:0]  m_addr = '0;
    logic        m_bank = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: each accepted write updates the latch or enqueues an expected pulse.
    always @(posedge clk) begin
        if (reset_n && host_valid && host_ready) begin
            if (!host_a[0]) begin
                m_addr = host_d;
                m_bank = host_a[1];
            end else begin
                exp_q.push_back({m_bank, m_addr, host_d});
                pushes++;
                acc_cyc = cyc;
            end
        end
    end

    // Scoreboard / monitor, sampled on the falling edge.
    always @(negedge clk) begin
        int lvl;
        cyc++;
        if (mon_en) begin
            if (opl3_reg_wr.valid) begin
                pulses++;
                check("pulse_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0)
                    check("pulse_fields", 32'({opl3_reg_wr.bank_num, opl3_reg_wr.address,
                                               opl3_reg_wr.data}), 32'(exp_q.pop_front()));
                if (pulse_cyc.size() > 0)
                    check("pulse_spacing_min", 32'((cyc - pulse_cyc[$]) >= SP), 32'd1);
                pulse_cyc.push_back(cyc);
            end
            lvl = pushes - pulses;
            check("fifo_level", 32'(fifo_level), 32'(lvl));
            check("host_ready", 32'(host_ready), 32'(lvl != DEPTH));
            if (fifo_level == 5'(DEPTH)) saw_full = 1'b1;
        end
    end

    task automatic host_write(input logic [1:0] a, input logic [7:0] d);
        int w = 0;
        host_valid = 1'b1;
        host_a     = a;
        host_d     = d;
        while (!host_ready && w < 400) begin
            @(negedge clk);
            w++;
            stalls++;
        end
        if (!host_ready) begin
            check("write_ready_timeout", 32'(host_ready), 32'd1);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        host_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 4000) begin
            @(negedge clk);
            w++;
        end
        check("drain_done", 32'(exp_q.size()), 32'd0);
        repeat (SP + 3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, p0, w;
        repeat (3) @(negedge clk);
        check("reset_ready", 32'(host_ready), 32'd0);
        check("reset_level", 32'(fifo_level), 32'd0);
        check("reset_reg_wr", 32'(opl3_reg_wr), 32'd0);
        check("reset_state", 32'(dbg_state), 32'(DRAIN_IDLE));
        reset_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        check("ready_after_release", 32'(host_ready), 32'd1);
        repeat (100) @(negedge clk);
        check("no_pulse_idle", 32'(pulses), 32'd0);

        // Single write: bank 0, addr 0xB0, data 0x20.
        host_write(2'd0, 8'hB0);
        host_write(2'd1, 8'h20);
        wait_drain();
        check("first_latency", 32'(pulse_cyc[$] - acc_cyc), 32'd2);

        // Bank 1 address reused by two data writes.
        host_write(2'd2, 8'hB3);
        host_write(2'd1, 8'h25);
        host_write(2'd3, 8'h05);
        wait_drain();
        n = pulse_cyc.size();
        check("pair_spacing", 32'(pulse_cyc[n-1] - pulse_cyc[n-2]), 32'(SP));

        // Four queued writes drain at the nominal rate.
        host_write(2'd0, 8'h41);
        for (int i = 0; i < 4; i++) host_write(2'd1, 8'(8'h10 + i));
        wait_drain();
        n = pulse_cyc.size();
        for (int i = 1; i <= 3; i++)
            check("quad_spacing", 32'(pulse_cyc[n-i] - pulse_cyc[n-i-1]), 32'(SP));

        // Back-to-back burst long enough to saturate the FIFO.
        stalls = 0;
        host_write(2'd2, 8'hA0);
        for (int i = 0; i < 40; i++) host_write(2'd1, 8'($urandom_range(0, 255)));
        wait_drain();
        check("burst_saw_full", 32'(saw_full), 32'd1);
        check("burst_stalled", 32'(stalls > 0), 32'd1);

        // Random mix of address and data writes with idle gaps.
        for (int i = 0; i < 300; i++) begin
            host_write(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
        end
        wait_drain();

        // Reset asserted mid-drain discards everything.
        host_write(2'd2, 8'h90);
        for (int i = 0; i < 10; i++) host_write(2'd1, 8'(8'hC0 + i));
        p0 = pulses;
        w  = 0;
        while (pulses < p0 + 2 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        check("mid_drain_progress", 32'(pulses >= p0 + 2), 32'd1);
        mon_en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_level", 32'(fifo_level), 32'd0);
        check("async_reset_valid", 32'(opl3_reg_wr.valid), 32'd0);
        check("async_reset_ready", 32'(host_ready), 32'd0);
        exp_q.delete();
        pulse_cyc.delete();
        pushes = 0;
        pulses = 0;
        m_addr = '0;
        m_bank = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        repeat (60) @(negedge clk);
        check("no_pulse_after_reset", 32'(pulses), 32'd0);
        host_write(2'd1, 8'h77);
        wait_drain();
        check("post_reset_pulses", 32'(pulses), 32'd1);
        check("post_reset_fields", 32'({opl3_reg_wr.bank_num, opl3_reg_wr.address,
                                        opl3_reg_wr.data}), 32'h00077);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
